// File: rtl/sr_flag_bank_if.sv
// Request/status bundle of the set/reset flag bank.
// The master drives set/reset/clear requests; the slave returns flag state and conflict status.
interface sr_flag_bank_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] conflict;
    logic             conflict_any;
    logic [CW-1:0]    count;

    modport master (
        output s, r, clr,
        input  q, nq, conflict, conflict_any, count
    );

    modport slave (
        input  s, r, clr,
        output q, nq, conflict, conflict_any, count
    );
endinterface

// File: rtl/sr_flag_bank.sv
// Bank of independent clocked set/reset flags with selectable conflict resolution,
// optional rising-edge triggering, sticky conflict capture and a registered popcount.
module sr_flag_cell #(
    parameter int MODE   = 0,
    parameter int EDGE   = 0,
    parameter bit INIT_B = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_i,
    input  logic r_i,
    input  logic clr_i,
    output logic q_o,
    output logic q_d_o,
    output logic conflict_o
);
    logic es, er;
    logic q_q, q_d;
    logic conf_q, conf_d;

    generate
        if (EDGE != 0) begin : g_edge
            logic s_hist_q, r_hist_q;

            // History tracks the raw inputs every edge, clr included, so a level
            // held across a clear does not re-fire once the clear drops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_hist_q <= 1'b0;
                    r_hist_q <= 1'b0;
                end else begin
                    s_hist_q <= s_i;
                    r_hist_q <= r_i;
                end
            end

            assign es = s_i & ~s_hist_q;
            assign er = r_i & ~r_hist_q;
        end else begin : g_level
            assign es = s_i;
            assign er = r_i;
        end
    endgenerate

    always_comb begin
        q_d    = q_q;
        conf_d = conf_q;
        if (clr_i) begin
            q_d    = INIT_B;
            conf_d = 1'b0;
        end else begin
            unique case ({es, er})
                2'b10: q_d = 1'b1;
                2'b01: q_d = 1'b0;
                2'b11: begin
                    conf_d = 1'b1;
                    case (MODE)
                        0:       q_d = 1'b0;
                        1:       q_d = 1'b1;
                        2:       q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= INIT_B;
            conf_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            conf_q <= conf_d;
        end
    end

    assign q_o        = q_q;
    assign q_d_o      = q_d;
    assign conflict_o = conf_q;
endmodule

module sr_flag_bank #(
    parameter int               WIDTH = 8,
    parameter int               MODE  = 0,
    parameter int               EDGE  = 0,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_flag_bank_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > 32 || MODE < 0 || MODE > 3 || EDGE < 0 || EDGE > 1) begin : g_bad_param
            $error("sr_flag_bank: illegal WIDTH/MODE/EDGE");
        end
    endgenerate

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    logic [WIDTH-1:0] q_vec, q_d_vec, conf_vec;
    logic [CW-1:0]    count_q, count_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            sr_flag_cell #(
                .MODE   (MODE),
                .EDGE   (EDGE),
                .INIT_B (INIT[i])
            ) u_cell (
                .clk        (clk),
                .rst_n      (rst_n),
                .s_i        (bus.s[i]),
                .r_i        (bus.r[i]),
                .clr_i      (bus.clr),
                .q_o        (q_vec[i]),
                .q_d_o      (q_d_vec[i]),
                .conflict_o (conf_vec[i])
            );
        end
    endgenerate

    // Counting the next state keeps count aligned with q on the same edge.
    assign count_d = popcount(q_d_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= popcount(INIT);
        else        count_q <= count_d;
    end

    assign bus.q            = q_vec;
    assign bus.nq           = ~q_vec;
    assign bus.conflict     = conf_vec;
    assign bus.conflict_any = |conf_vec;
    assign bus.count        = count_q;
endmodule
